// File: rtl/fifo_stream_out.sv
// Read-side adapter for fifo_sync: issues FIFO reads, absorbs the 1-cycle read latency in a
// 3-entry skid buffer and presents a valid/ready stream. Optional FIFO_STREAM_CNT_EN adds word_cnt/stall.
module fifo_stream_out #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_STREAM_CNT_EN
    ,
    output logic [31:0]           word_cnt,
    output logic                  stall
`endif
);

    localparam int DEPTH = 3;

    logic [1:0]            count_q, count_d;
    logic                  inflight_q;
    logic [1:0]            wptr_q, wptr_d;
    logic [1:0]            rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] buf_q [DEPTH];

    logic [2:0] occ;
    logic       capture;
    logic       pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Occupancy counts words already held plus the one returning next cycle, so a read
    // is only issued when a slot is guaranteed; m_ready never reaches fifo_rd_en.
    assign occ        = {1'b0, count_q} + {2'b00, inflight_q};
    assign fifo_cs    = enable;
    assign fifo_rd_en = enable && !fifo_empty && (occ < 3'(DEPTH));

    assign capture = inflight_q;
    assign m_valid = (count_q != 2'd0);
    assign pop     = m_valid && m_ready;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (capture) wptr_d = ptr_inc(wptr_q);
        if (pop)     rptr_d = ptr_inc(rptr_q);
        if (capture && !pop)      count_d = count_q + 2'd1;
        else if (!capture && pop) count_d = count_q - 2'd1;
    end

    always_comb begin
        case (rptr_q)
            2'd1:    m_data = buf_q[1];
            2'd2:    m_data = buf_q[2];
            default: m_data = buf_q[0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            inflight_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= fifo_rd_en;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (capture && (wptr_q == 2'(i))) buf_q[i] <= fifo_data;
        end
    end

`ifdef FIFO_STREAM_CNT_EN
    logic [31:0] word_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   word_cnt_q <= '0;
        else if (pop) word_cnt_q <= word_cnt_q + 32'd1;
    end

    assign word_cnt = word_cnt_q;
    assign stall    = m_valid && !m_ready;
`endif

    // A capture into a full buffer without a simultaneous pop would overwrite the head.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && (count_q == 2'd3) && !pop));
    a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n) occ <= 3'(DEPTH));

endmodule
